// File: rtl/max_pool_2x2_if.sv
// rtl/max_pool_2x2_if.sv - sample stream bundle for the 2x2 max-pool stage
interface max_pool_2x2_if #(
  parameter int N = 3
);
  logic [N-1:0] d_in;
  logic         en_in;
  logic [N-1:0] d_out;
  logic         en_out;
  logic         frame_end;

  modport master (
    output d_in, en_in,
    input  d_out, en_out, frame_end
  );

  modport slave (
    input  d_in, en_in,
    output d_out, en_out, frame_end
  );
endinterface

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - 2x2 stride-2 signed max pooling over a raster-ordered feature map
// Even rows park horizontal pair maxima in a line buffer; odd rows finish each window.
module max_pool_2x2 #(
  parameter int N     = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic          clk,
  input  logic          rst,
  max_pool_2x2_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LD = IMG_W / 2;
  localparam int IW = (LD > 1) ? $clog2(LD) : 1;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic signed [N-1:0]   r_pair;
  logic signed [N-1:0]   r_d_out;
  logic                  r_en_out;
  logic                  r_frame_end;
  logic signed [N-1:0]   r_lbuf [LD];

  logic signed [N-1:0]   w_d_in;
  logic signed [N-1:0]   w_hmax;
  logic signed [N-1:0]   w_vmax;
  logic [IW-1:0]         w_idx;
  logic                  w_col_last;
  logic                  w_row_last;

  function automatic logic signed [N-1:0] smax(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_d_in     = $signed(bus.d_in);
  assign w_idx      = IW'(r_col >> 1);
  assign w_hmax     = smax(r_pair, w_d_in);
  assign w_vmax     = smax(r_lbuf[w_idx], w_hmax);
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));

  // Line buffer is never reset: every entry is written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (!rst && bus.en_in && r_col[0] && !r_row[0]) begin
      r_lbuf[w_idx] <= w_hmax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_pair      <= '0;
      r_d_out     <= '0;
      r_en_out    <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_en_out    <= 1'b0;
      r_frame_end <= 1'b0;
      if (bus.en_in) begin
        if (!r_col[0]) begin
          r_pair <= w_d_in;
        end else if (r_row[0]) begin
          r_d_out     <= w_vmax;
          r_en_out    <= 1'b1;
          r_frame_end <= w_col_last && w_row_last;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign bus.d_out     = r_d_out;
  assign bus.en_out    = r_en_out;
  assign bus.frame_end = r_frame_end;
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - self-checking bench for max_pool_2x2 (4x2 and default 8x8 instances)
module tb_max_pool_2x2;
  logic clk;
  logic rst;
  bit   sel;
  int   checks;
  int   failures;
  int   k_s, k_d;
  int   last_s, last_d;
  int   fr_s [8];
  int   fr_d [64];
  int   n_en, n_fe;

  max_pool_2x2_if #(.N(3)) bs ();
  max_pool_2x2_if #(.N(3)) bd ();

  max_pool_2x2 #(.N(3), .IMG_W(4), .IMG_H(2)) dut_s (.clk(clk), .rst(rst), .bus(bs));
  max_pool_2x2 #(.N(3), .IMG_W(8), .IMG_H(8)) dut_d (.clk(clk), .rst(rst), .bus(bd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frv(input int i);
    return sel ? fr_d[i] : fr_s[i];
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One clock: optionally present a sample to the selected instance, then check both.
  task automatic step(input bit en, input int v);
    int w, h, k, r, c, sv, exp_d, obs_d;
    bit win, fe, obs_en, obs_fe, oth_en;
    logic signed [2:0] t;
    t = v[2:0];
    sv = int'(t);
    w = sel ? 8 : 4;
    h = sel ? 8 : 2;
    k = sel ? k_d : k_s;
    win = 1'b0;
    fe = 1'b0;
    exp_d = sel ? last_d : last_s;
    if (en) begin
      r = k / w;
      c = k % w;
      if (sel) fr_d[k] = sv; else fr_s[k] = sv;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        win = 1'b1;
        exp_d = max4(frv(k - w - 1), frv(k - w), frv(k - 1), sv);
        fe = (r == h - 1) && (c == w - 1);
      end
    end
    bs.d_in  = t;
    bd.d_in  = t;
    bs.en_in = en && !sel;
    bd.en_in = en && sel;
    @(posedge clk);
    #1;
    if (sel) begin
      obs_en = bd.en_out; obs_d = int'($signed(bd.d_out)); obs_fe = bd.frame_end; oth_en = bs.en_out;
    end else begin
      obs_en = bs.en_out; obs_d = int'($signed(bs.d_out)); obs_fe = bs.frame_end; oth_en = bd.en_out;
    end
    check(sel ? "dflt_en_out" : "small_en_out", obs_en, win);
    check(sel ? "dflt_d_out" : "small_d_out", obs_d, exp_d);
    check(sel ? "dflt_frame_end" : "small_frame_end", obs_fe, fe);
    check("idle_instance_en_out", oth_en, 0);
    if (sel) last_d = exp_d; else last_s = exp_d;
    if (en) k = (k + 1) % (w * h);
    if (sel) k_d = k; else k_s = k;
    if (win) n_en++;
    if (fe) n_fe++;
  endtask

  task automatic do_reset(input bit en);
    rst = 1'b1;
    bs.en_in = en; bd.en_in = en;
    bs.d_in = 3'd3; bd.d_in = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_small_d_out", int'(bs.d_out), 0);
      check("rst_small_en_out", bs.en_out, 0);
      check("rst_small_frame_end", bs.frame_end, 0);
      check("rst_dflt_d_out", int'(bd.d_out), 0);
      check("rst_dflt_en_out", bd.en_out, 0);
      check("rst_dflt_frame_end", bd.frame_end, 0);
    end
    rst = 1'b0;
    bs.en_in = 1'b0; bd.en_in = 1'b0;
    k_s = 0; k_d = 0; last_s = 0; last_d = 0;
  endtask

  initial begin
    int f2 [8];
    checks = 0; failures = 0;
    n_en = 0; n_fe = 0;
    sel = 1'b0;
    f2 = '{1, -2, 3, 0, -4, 2, -1, -3};

    // Reset with en_in low, then with en_in high to show reset dominates.
    do_reset(1'b0);
    step(1'b0, 0);
    step(1'b0, 0);
    do_reset(1'b1);

    // Directed 4x2 frame, continuous strobe.
    sel = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, f2[i]);
    step(1'b0, 0);

    // Same frame, strobe gapped every other cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, f2[i]);
      step(1'b0, 0);
    end

    // Min then max signed, back-to-back frames.
    for (int i = 0; i < 8; i++) step(1'b1, -4);
    for (int i = 0; i < 8; i++) step(1'b1, 3);
    step(1'b0, 0);

    // Abort after 5 samples, then full frame.
    for (int i = 0; i < 5; i++) step(1'b1, f2[i]);
    do_reset(1'b0);
    step(1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, f2[i]);

    // Default-size instance: 3 ramp frames, window/frame_end counts per frame.
    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n_en = 0; n_fe = 0;
      for (int i = 0; i < 64; i++) step(1'b1, ((f * 64 + i) % 8) - 4);
      check("ramp_windows_per_frame", n_en, 16);
      check("ramp_frame_end_per_frame", n_fe, 1);
    end

    // Randomized data and gaps on both instances.
    for (int f = 0; f < 4; f++) begin
      sel = f[0];
      n_en = 0; n_fe = 0;
      for (int i = 0; i < (sel ? 64 : 8); i++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 0);
        step(1'b1, int'($urandom_range(0, 7)));
      end
      step(1'b0, 0);
      check("rand_windows_per_frame", n_en, sel ? 16 : 2);
      check("rand_frame_end_per_frame", n_fe, 1);
    end

    // Random abort point on the default instance, then a clean random frame.
    sel = 1'b1;
    for (int i = 0; i < int'($urandom_range(1, 63)); i++) step(1'b1, int'($urandom_range(0, 7)));
    do_reset(1'b0);
    n_en = 0; n_fe = 0;
    for (int i = 0; i < 64; i++) step(1'b1, int'($urandom_range(0, 7)));
    check("post_abort_windows", n_en, 16);
    check("post_abort_frame_end", n_fe, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
